// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_if
// Brief    : Pipeline-to-hazard-unit signal bundle (register tags, stage
//            controls, stall/flush/forward results).
// Revision : 1.0  initial release
// ============================================================================
interface hazard_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                  RegWriteE, RegWriteM, RegWriteW;
  logic                  ResultSrcE0, PCSrcE, MulDivStartE;
  logic                  StallF, StallD, StallE;
  logic                  FlushD, FlushE, FlushM;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  MulDivDoneE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW,
    output ResultSrcE0, PCSrcE, MulDivStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, MulDivDoneE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW,
    input  ResultSrcE0, PCSrcE, MulDivStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, MulDivDoneE
  );
endinterface
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Brief    : Stall/flush/forward control for a 5-stage pipeline with a
//            multi-cycle mul/div sequencer. Macro HAZARD_FORWARDING_EN
//            enables E-stage forwarding; otherwise RAW hazards stall.
// Revision : 1.0  initial release
// ============================================================================
module hazard_controller #(
  parameter int MULDIV_LATENCY = 4,
  parameter int REG_ADDR_W     = 5
) (
  input  wire logic clk,
  input  wire logic rst,
  hazard_if.slave   hz
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [3:0]            c_CNT_INIT = 4'(MULDIV_LATENCY - 2);
  localparam logic [REG_ADDR_W-1:0] c_X0       = '0;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_busy_stall, w_done;
  logic       w_lw_stall, w_raw_stall;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Start is ignored once BUSY: the op stays in E until the count expires.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_busy_stall = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (hz.MulDivStartE) begin
          w_busy_stall = 1'b1;
          w_cnt_nxt    = c_CNT_INIT;
          w_state_nxt  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_busy_stall = 1'b1;
          w_cnt_nxt    = r_cnt - 4'd1;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_lw_stall = hz.ResultSrcE0 && (hz.RdE != c_X0) &&
                      ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

`ifdef HAZARD_FORWARDING_EN
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  wm,
    input logic [REG_ADDR_W-1:0] rdm,
    input logic                  ww,
    input logic [REG_ADDR_W-1:0] rdw
  );
    if (wm && (rdm == rs) && (rdm != c_X0))
      return 2'b10;
    else if (ww && (rdw == rs) && (rdw != c_X0))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_fwd_a     = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign w_fwd_b     = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign w_raw_stall = w_lw_stall;
  assign w_unused    = hz.RegWriteE;
`else
  // Without forwarding, any in-flight E/M producer of a D source must stall;
  // W producers are covered by the register file's write-before-read.
  assign w_fwd_a     = 2'b00;
  assign w_fwd_b     = 2'b00;
  assign w_raw_stall = w_lw_stall ||
      (hz.RegWriteE && (hz.RdE != c_X0) &&
       ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE))) ||
      (hz.RegWriteM && (hz.RdM != c_X0) &&
       ((hz.Rs1D == hz.RdM) || (hz.Rs2D == hz.RdM)));
  assign w_unused    = ^{hz.Rs1E, hz.Rs2E, hz.RdW, hz.RegWriteW};
`endif

  // A held mul/div in E masks both the branch flush and the load-use bubble.
  always_comb begin
    hz.StallF      = 1'b0;
    hz.StallD      = 1'b0;
    hz.StallE      = 1'b0;
    hz.FlushD      = 1'b1;
    hz.FlushE      = 1'b1;
    hz.FlushM      = 1'b1;
    hz.ForwardAE   = 2'b00;
    hz.ForwardBE   = 2'b00;
    hz.MulDivDoneE = 1'b0;
    if (!rst) begin
      hz.StallF      = (w_raw_stall && !hz.PCSrcE) || w_busy_stall;
      hz.StallD      = w_raw_stall || w_busy_stall;
      hz.StallE      = w_busy_stall;
      hz.FlushD      = hz.PCSrcE && !w_busy_stall;
      hz.FlushE      = (w_raw_stall || hz.PCSrcE) && !w_busy_stall;
      hz.FlushM      = w_busy_stall;
      hz.ForwardAE   = w_fwd_a;
      hz.ForwardBE   = w_fwd_b;
      hz.MulDivDoneE = w_done;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Brief    : Directed-vector scoreboard bench for hazard_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_controller;

`ifdef HAZARD_FORWARDING_EN
  localparam bit c_FWD = 1'b1;
`else
  localparam bit c_FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_if #(.REG_ADDR_W(5)) hz ();
  hazard_if #(.REG_ADDR_W(5)) hz2 ();

  hazard_controller #(.MULDIV_LATENCY(4), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  hazard_controller #(.MULDIV_LATENCY(2), .REG_ADDR_W(5)) dut_l2 (
    .clk (clk),
    .rst (rst),
    .hz  (hz2.slave)
  );

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,ForwardAE,ForwardBE,MulDivDoneE}
  logic [10:0] o1, o2;
  assign o1 = {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
               hz.ForwardAE, hz.ForwardBE, hz.MulDivDoneE};
  assign o2 = {hz2.StallF, hz2.StallD, hz2.StallE, hz2.FlushD, hz2.FlushE, hz2.FlushM,
               hz2.ForwardAE, hz2.ForwardBE, hz2.MulDivDoneE};

  typedef struct {
    string       nm;
    logic [10:0] ex;
    bit          sel;
  } chk_t;
  chk_t q[$];

  int n_pass  = 0;
  int n_total = 0;

  logic [4:0] s_rs1d, s_rs2d, s_rs1e, s_rs2e, s_rde, s_rdm, s_rdw;
  logic       s_rwe, s_rwm, s_rww, s_ld, s_pc, s_start, s_rst;

  function automatic logic [10:0] e(input bit sf, sd, se, fd, fe, fm,
                                    input logic [1:0] fa, fb, input bit dn);
    return {sf, sd, se, fd, fe, fm, fa, fb, dn};
  endfunction

  localparam logic [10:0] c_RST  = 11'b000_111_00_00_0;
  localparam logic [10:0] c_ZERO = 11'b000_000_00_00_0;
  localparam logic [10:0] c_BUSY = 11'b111_001_00_00_0;

  task automatic clr();
    {s_rs1d, s_rs2d, s_rs1e, s_rs2e, s_rde, s_rdm, s_rdw} = '0;
    {s_rwe, s_rwm, s_rww, s_ld, s_pc, s_start, s_rst}     = '0;
  endtask

  task automatic step(input string nm, input logic [10:0] ex, input bit sel);
    chk_t c;
    @(posedge clk);
    #1;
    rst = s_rst;
    hz.Rs1D = s_rs1d;  hz.Rs2D = s_rs2d;  hz.Rs1E = s_rs1e;  hz.Rs2E = s_rs2e;
    hz.RdE = s_rde;    hz.RdM = s_rdm;    hz.RdW = s_rdw;
    hz.RegWriteE = s_rwe; hz.RegWriteM = s_rwm; hz.RegWriteW = s_rww;
    hz.ResultSrcE0 = s_ld; hz.PCSrcE = s_pc; hz.MulDivStartE = s_start;
    hz2.Rs1D = s_rs1d; hz2.Rs2D = s_rs2d; hz2.Rs1E = s_rs1e; hz2.Rs2E = s_rs2e;
    hz2.RdE = s_rde;   hz2.RdM = s_rdm;   hz2.RdW = s_rdw;
    hz2.RegWriteE = s_rwe; hz2.RegWriteM = s_rwm; hz2.RegWriteW = s_rww;
    hz2.ResultSrcE0 = s_ld; hz2.PCSrcE = s_pc; hz2.MulDivStartE = s_start;
    c.nm  = nm;
    c.ex  = ex;
    c.sel = sel;
    q.push_back(c);
  endtask

  // Monitor: the outputs are combinational, so each issued vector is judged
  // mid-cycle, half a period after it was applied.
  initial begin
    chk_t        c;
    logic [10:0] got;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        c   = q.pop_front();
        got = c.sel ? o2 : o1;
        n_total++;
        if (got === c.ex)
          n_pass++;
        else
          $display("FAIL %s: got %b required %b", c.nm, got, c.ex);
      end
    end
  end

  initial begin
    clr();
    s_rst = 1'b1;
    step("reset", c_RST, 0);
    s_rwm = 1; s_rdm = 5; s_rs1e = 5; s_ld = 1; s_rde = 7; s_rs2d = 7; s_pc = 1; s_start = 1;
    step("reset_hold", c_RST, 0);
    clr();
    step("idle", c_ZERO, 0);

    // Forwarding
    clr(); s_rwm = 1; s_rdm = 5; s_rww = 1; s_rdw = 5; s_rs1e = 5; s_rs2e = 6;
    step("fwd_m_pri", e(0,0,0,0,0,0, c_FWD ? 2'b10 : 2'b00, 2'b00, 0), 0);
    s_rdw = 6;
    step("fwd_w_b", e(0,0,0,0,0,0, c_FWD ? 2'b10 : 2'b00, c_FWD ? 2'b01 : 2'b00, 0), 0);
    s_rdm = 0; s_rs1e = 0;
    step("fwd_x0", e(0,0,0,0,0,0, 2'b00, c_FWD ? 2'b01 : 2'b00, 0), 0);
    s_rdm = 6;
    step("fwd_b_m_pri", e(0,0,0,0,0,0, 2'b00, c_FWD ? 2'b10 : 2'b00, 0), 0);

    // Load-use and branches
    clr(); s_ld = 1; s_rde = 7; s_rs2d = 7;
    step("loaduse", e(1,1,0,0,1,0, 2'b00, 2'b00, 0), 0);
    s_ld = 0;
    step("loaduse_clear", c_ZERO, 0);
    s_ld = 1; s_pc = 1;
    step("loaduse_branch", e(0,1,0,1,1,0, 2'b00, 2'b00, 0), 0);
    clr(); s_ld = 1;
    step("loaduse_x0", c_ZERO, 0);
    clr(); s_pc = 1;
    step("branch", e(0,0,0,1,1,0, 2'b00, 2'b00, 0), 0);

    // RAW stalls when forwarding is absent
    clr(); s_rwm = 1; s_rdm = 3; s_rs1d = 3;
    step("raw_m", c_FWD ? c_ZERO : e(1,1,0,0,1,0, 2'b00, 2'b00, 0), 0);
    clr(); s_rwe = 1; s_rde = 4; s_rs2d = 4;
    step("raw_e", c_FWD ? c_ZERO : e(1,1,0,0,1,0, 2'b00, 2'b00, 0), 0);
    clr(); s_rwm = 1; s_rdm = 3; s_rs1d = 3; s_pc = 1;
    step("raw_branch", c_FWD ? e(0,0,0,1,1,0, 2'b00, 2'b00, 0)
                             : e(0,1,0,1,1,0, 2'b00, 2'b00, 0), 0);
    clr(); s_rwm = 1; s_rwe = 1;
    step("raw_x0", c_ZERO, 0);

    // Mul/div, latency 4
    clr(); s_start = 1;
    step("md_c1", c_BUSY, 0);
    s_pc = 1;
    step("md_c2_branch", c_BUSY, 0);
    s_pc = 0; s_ld = 1; s_rde = 7; s_rs2d = 7;
    step("md_c3_loaduse", c_BUSY, 0);
    clr(); s_start = 1;
    step("md_done", e(0,0,0,0,0,0, 2'b00, 2'b00, 1), 0);
    clr();
    step("md_idle", c_ZERO, 0);

    // Reset in the middle of an op
    clr(); s_start = 1;
    step("rm_c1", c_BUSY, 0);
    s_rst = 1;
    step("rm_rst", c_RST, 0);
    clr();
    step("rm_post", c_ZERO, 0);

    // Latency 2: exactly one stall cycle
    clr(); s_start = 1;
    step("l2_c1", c_BUSY, 1);
    step("l2_done", e(0,0,0,0,0,0, 2'b00, 2'b00, 1), 1);
    clr();
    step("l2_after", c_ZERO, 1);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central hazard controller for the 5-stage pipeline (F/D/E/M/W).
- Generates stall and flush controls for every pipeline register. StallD drives EN and FlushD drives CLR of the F/D register.
- Generates E-stage forwarding selects.
- Sequences multi-cycle mul/div ops in E with an internal countdown FSM that holds the front of the pipe and bubbles M.

Parameters:
- MULDIV_LATENCY, 4: total cycles a mul/div op occupies E; legal range 2..16.
- REG_ADDR_W, 5: register address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- Rs1D, Rs2D  in  REG_ADDR_W  source registers in D
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  source/destination registers in E
- RdM, RdW  in  REG_ADDR_W  destination registers in M and W
- RegWriteE, RegWriteM, RegWriteW  in  1  writeback enables per stage
- ResultSrcE0  in  1  E-stage instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- MulDivStartE  in  1  E-stage instruction is mul/div
- StallF, StallD, StallE  out  1  hold PC, F/D and D/E registers
- FlushD, FlushE, FlushM  out  1  clear F/D, D/E and E/M registers
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = from M, 01 = from W
- MulDivDoneE  out  1  final cycle of a mul/div op in E

Behaviour:
- State is registered on the clk rising edge. All outputs are combinational from inputs and state (zero latency).
- Reset: rst=1 forces state IDLE and cnt=0.
- While rst=1:
  - StallF/D/E=0
  - FlushD/E/M=1
  - ForwardAE/BE=00
  - MulDivDoneE=0
- Register x0 never matches: any Rd equal to 0 is ignored for forwarding and stalls.
- Forwarding, ForwardAE (ForwardBE identical with Rs2E):
  - 10 if RegWriteM & RdM==Rs1E & RdM!=0.
  - Otherwise 01 if RegWriteW & RdW==Rs1E & RdW!=0.
  - Otherwise 00.
  - M has priority over W.
- Load-use: lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- Mul/div FSM, states IDLE and BUSY, down-counter cnt of 4 bits.
  - IDLE & MulDivStartE: busyStall=1; cnt<=MULDIV_LATENCY-2; next state BUSY.
  - BUSY & cnt!=0: busyStall=1; cnt<=cnt-1.
  - BUSY & cnt==0: busyStall=0; MulDivDoneE=1; next state IDLE.
  - Net effect: the op holds E for exactly MULDIV_LATENCY cycles. busyStall is high for the first MULDIV_LATENCY-1 of them.
  - MulDivStartE stays high while the op sits in E. It is ignored in BUSY; there is no retrigger.
- Output equations:
  - StallF = (lwStall & ~PCSrcE) | busyStall
  - StallD = lwStall | busyStall
  - StallE = busyStall
  - FlushD = PCSrcE & ~busyStall
  - FlushE = (lwStall | PCSrcE) & ~busyStall
  - FlushM = busyStall (inserts a bubble behind the held op)
- Simultaneous events:
  - Load-use with PCSrcE: the flush wins. FlushD=FlushE=1, StallF=0 so the PC takes the branch target. StallD=1 is harmless because CLR dominates EN in the F/D register.
  - lwStall during busyStall: stall only, no FlushE. E must keep the mul/div op.
  - PCSrcE during BUSY: masked. A branch cannot be resolved while E is held.
- Reset mid-operation: asserting rst in BUSY returns to IDLE on that edge. All stalls drop in the first cycle after rst deasserts.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: forwarding as specified above.
- Undefined:
  - ForwardAE/BE are tied to 00.
  - The RAW stall widens to rawStall = lwStall | any D source matching RdE (RegWriteE) or RdM (RegWriteM), Rd!=0.
  - rawStall replaces lwStall in every output equation.
  - W-stage hazards rely on the register file's write-before-read.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=6 -> ForwardAE=10, ForwardBE=00. Then RdW=6 with RdM=5 unchanged -> ForwardBE=01. Then RdM=0, Rs1E=0 -> ForwardAE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0. Next cycle, with ResultSrcE0=0 -> all stall/flush outputs 0.
- Branch with load-use: PCSrcE=1 in the same cycle as the load-use condition above -> FlushD=FlushE=1, StallF=0.
- Mul/div, MULDIV_LATENCY=4: MulDivStartE held high -> StallF/D/E=FlushM=1 for 3 cycles, then in the 4th cycle MulDivDoneE=1 and stalls are 0. PCSrcE=1 injected in cycle 2 -> FlushD=FlushE=0.
- Reset mid-op: rst=1 in cycle 2 of a mul/div op -> during reset FlushD/E/M=1 and stalls 0. The first post-reset cycle has MulDivStartE=0 and all outputs 0. MULDIV_LATENCY=2 variant: exactly one stall cycle.
- HAZARD_FORWARDING_EN undefined: RegWriteM=1, RdM=3, Rs1D=3 -> StallD=StallF=FlushE=1, ForwardAE=00.
